// File: rtl/doodle_y_if.sv
// doodle_y_if
// -----------
// Bundles the game-side signals of the vertical-motion block so the renderer,
// the platform generator and the motion controller share one connection.
//
// Signals:
//   d_x                 doodle left edge, from the horizontal position block
//   p1..p3_hpos         platform left edges
//   p1..p3_vpos         platform top edges
//   d_y                 doodle top edge, to the renderer
//   falling             high while the doodle is in free fall
//   bounce              one-tick pulse on a landing
//   game_over           sticky until reset
//
// Modports:
//   master  the game side, which drives positions and reads motion status
//   slave   the vertical-motion controller
interface doodle_y_if;
  logic [9:0] d_x;
  logic [9:0] p1_hpos;
  logic [9:0] p2_hpos;
  logic [9:0] p3_hpos;
  logic [9:0] p1_vpos;
  logic [9:0] p2_vpos;
  logic [9:0] p3_vpos;
  logic [9:0] d_y;
  logic       falling;
  logic       bounce;
  logic       game_over;

  modport master (
    output d_x, p1_hpos, p2_hpos, p3_hpos, p1_vpos, p2_vpos, p3_vpos,
    input  d_y, falling, bounce, game_over
  );

  modport slave (
    input  d_x, p1_hpos, p2_hpos, p3_hpos, p1_vpos, p2_vpos, p3_vpos,
    output d_y, falling, bounce, game_over
  );
endinterface

// File: rtl/doodle_y.sv
// doodle_y
// --------
// Vertical-motion controller for the doodle sprite. On every game tick it
// advances a jump cycle: RISE at constant speed, a short hover at APEX, then
// FALL with gravity, during which it looks for a platform to land on. A
// landing snaps the feet onto the platform top and starts a new jump. Falling
// past the bottom of the play field ends the game until reset.
//
// Ports:
//   doodle_clk  game tick clock, all state changes on its rising edge
//   rst         synchronous active-high reset
//   bus         doodle_y_if.slave: d_x and platform positions in;
//               d_y, falling, bounce, game_over out (all registered)
module doodle_y (
  input  logic      doodle_clk,
  input  logic      rst,
  doodle_y_if.slave bus
);

  // Geometry, in 11 bits so that sums like feet + speed never wrap.
  localparam logic [10:0] VTOP      = 11'd31;
  localparam logic [10:0] BOTTOM    = 11'd511;
  localparam logic [10:0] SIZE      = 11'd50;
  localparam logic [10:0] P_WIDTH   = 11'd75;
  localparam logic [10:0] RISE_STEP = 11'd3;

  // The same constants in the 10-bit width of d_y.
  localparam logic [9:0]  VTOP_Y      = 10'd31;
  localparam logic [9:0]  SIZE_Y      = 10'd50;
  localparam logic [9:0]  RISE_STEP_Y = 10'd3;
  localparam logic [9:0]  Y_REST      = 10'd461;

  // Counters stop at the last tick of their phase rather than counting past it.
  localparam logic [5:0]  JUMP_LAST = 6'd49;
  localparam logic [1:0]  APEX_LAST = 2'd3;
  localparam logic [1:0]  GRAV_LAST = 2'd3;
  localparam logic [2:0]  V_MAX     = 3'd6;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    APEX = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  dy_q, dy_d;
  logic [5:0]  rise_cnt_q, rise_cnt_d;
  logic [1:0]  apex_cnt_q, apex_cnt_d;
  logic [2:0]  v_q, v_d;
  logic [1:0]  gcnt_q, gcnt_d;
  logic        falling_q, falling_d;
  logic        bounce_q, bounce_d;
  logic        game_over_q, game_over_d;

  logic [10:0] feet;
  logic [10:0] feet_next;
  logic        land1, land2, land3;
  logic        landed;
  logic [9:0]  land_vpos;

  // A platform catches the doodle when the two overlap horizontally (touching
  // edges do not count) and the feet are at or above the platform top now but
  // would reach or pass it with this tick's fall speed.
  function automatic logic lands(
    input logic [9:0]  dx,
    input logic [9:0]  hpos,
    input logic [9:0]  vpos,
    input logic [10:0] feet_now,
    input logic [10:0] feet_after
  );
    logic overlap;
    logic crossing;
    overlap  = (({1'b0, dx} + SIZE) > {1'b0, hpos}) &&
               ({1'b0, dx} < ({1'b0, hpos} + P_WIDTH));
    crossing = (feet_now <= {1'b0, vpos}) && (feet_after >= {1'b0, vpos});
    return overlap && crossing;
  endfunction

  // Landing detection uses the pre-edge position and speed, with the
  // platforms sampled as they stand on this edge.
  always_comb begin
    feet      = {1'b0, dy_q} + SIZE;
    feet_next = feet + {8'b0, v_q};
    land1     = lands(bus.d_x, bus.p1_hpos, bus.p1_vpos, feet, feet_next);
    land2     = lands(bus.d_x, bus.p2_hpos, bus.p2_vpos, feet, feet_next);
    land3     = lands(bus.d_x, bus.p3_hpos, bus.p3_vpos, feet, feet_next);
  end

  // When several platforms catch the doodle in the same tick, the lowest
  // numbered one wins.
  always_comb begin
    landed    = 1'b0;
    land_vpos = '0;
    if (land1) begin
      landed    = 1'b1;
      land_vpos = bus.p1_vpos;
    end else if (land2) begin
      landed    = 1'b1;
      land_vpos = bus.p2_vpos;
    end else if (land3) begin
      landed    = 1'b1;
      land_vpos = bus.p3_vpos;
    end
  end

  // Next-state logic for the jump cycle. Everything holds by default, so
  // DEAD needs no branch of its own; bounce defaults low so it only lasts
  // one tick after a landing.
  always_comb begin
    state_d     = state_q;
    dy_d        = dy_q;
    rise_cnt_d  = rise_cnt_q;
    apex_cnt_d  = apex_cnt_q;
    v_d         = v_q;
    gcnt_d      = gcnt_q;
    bounce_d    = 1'b0;
    game_over_d = game_over_q;

    case (state_q)
      RISE: begin
        // Clamp at the top of the field without ever going below zero.
        if ({1'b0, dy_q} < (VTOP + RISE_STEP)) begin
          dy_d = VTOP_Y;
        end else begin
          dy_d = dy_q - RISE_STEP_Y;
        end
        if (rise_cnt_q == JUMP_LAST) begin
          state_d    = APEX;
          rise_cnt_d = '0;
          apex_cnt_d = '0;
        end else begin
          rise_cnt_d = rise_cnt_q + 6'd1;
        end
      end

      APEX: begin
        if (apex_cnt_q == APEX_LAST) begin
          state_d    = FALL;
          apex_cnt_d = '0;
          v_d        = 3'd1;
          gcnt_d     = '0;
        end else begin
          apex_cnt_d = apex_cnt_q + 2'd1;
        end
      end

      FALL: begin
        if (landed) begin
          dy_d       = land_vpos - SIZE_Y;
          bounce_d   = 1'b1;
          state_d    = RISE;
          rise_cnt_d = '0;
        end else if (feet_next > BOTTOM) begin
          dy_d        = Y_REST;
          game_over_d = 1'b1;
          state_d     = DEAD;
        end else begin
          dy_d = dy_q + {7'b0, v_q};
          // Speed goes up once every four fall ticks, using the old speed
          // for the move on the tick where it changes.
          if (gcnt_q == GRAV_LAST) begin
            gcnt_d = '0;
            if (v_q != V_MAX) begin
              v_d = v_q + 3'd1;
            end
          end else begin
            gcnt_d = gcnt_q + 2'd1;
          end
        end
      end

      DEAD: begin
        game_over_d = 1'b1;
      end

      default: begin
        state_d = RISE;
      end
    endcase

    falling_d = (state_d == FALL);
  end

  // State and output registers. Reset wins over every state, DEAD included,
  // and puts the doodle back on the floor at the start of a fresh jump.
  always_ff @(posedge doodle_clk) begin
    if (rst) begin
      state_q     <= RISE;
      dy_q        <= Y_REST;
      rise_cnt_q  <= '0;
      apex_cnt_q  <= '0;
      v_q         <= 3'd1;
      gcnt_q      <= '0;
      falling_q   <= 1'b0;
      bounce_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dy_q        <= dy_d;
      rise_cnt_q  <= rise_cnt_d;
      apex_cnt_q  <= apex_cnt_d;
      v_q         <= v_d;
      gcnt_q      <= gcnt_d;
      falling_q   <= falling_d;
      bounce_q    <= bounce_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.d_y       = dy_q;
  assign bus.falling   = falling_q;
  assign bus.bounce    = bounce_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_doodle_y.sv
// tb_doodle_y
// -----------
// Self-checking bench for doodle_y. A behavioural model tracks the jump as
// "ticks since launch" and derives fall speed arithmetically from that time;
// every tick the DUT outputs are compared with it. A table of scripted
// segments adds fixed expectations for the reset/rise/gravity/landing story,
// followed by hand-written priority and edge-contact/death sequences and a
// randomized run.
//
// Ports: none (top-level bench).
module tb_doodle_y;

  logic doodle_clk = 1'b0;
  logic rst;

  doodle_y_if bus ();

  doodle_y dut (
    .doodle_clk (doodle_clk),
    .rst        (rst),
    .bus        (bus)
  );

  // Ten time-unit game tick.
  always #5 doodle_clk = ~doodle_clk;

  localparam logic [9:0] OFF = 10'd900;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus currently applied to the DUT.
  bit         curRst;
  logic [9:0] curDx;
  logic [9:0] curH [3];
  logic [9:0] curV [3];

  // Reference model state.
  int mY;
  int mT;
  bit mDead;
  bit mBounce;
  bit mFalling;
  bit mGo;

  typedef struct {
    bit         rst;
    logic [9:0] dx;
    logic [9:0] p1h;
    logic [9:0] p1v;
    logic [9:0] p2h;
    logic [9:0] p2v;
    int         ticks;
    logic [9:0] expDy;
    bit         expFalling;
    bit         expBounce;
    bit         expGo;
  } vec_t;

  vec_t tbl [11];

  // One comparison: counts it and reports a FAIL line on a mismatch.
  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a jump is 50 rise ticks, 4 apex ticks, then fall
  // with speed min(1 + fallTicks/4, 6). A landing restarts the jump clock.
  task automatic modelStep();
    int v;
    int feet;
    int x;
    int h;
    int p;
    bit hit;
    mBounce = 1'b0;
    if (curRst) begin
      mY = 461; mT = 0; mDead = 1'b0; mGo = 1'b0; mFalling = 1'b0;
      return;
    end
    if (mDead) begin
      mFalling = 1'b0;
      return;
    end
    if (mT < 50) begin
      mY = (mY - 3 < 31) ? 31 : mY - 3;
      mT++;
    end else if (mT < 54) begin
      mT++;
    end else begin
      v = 1 + (mT - 54) / 4;
      if (v > 6) v = 6;
      feet = mY + 50;
      x = int'(curDx);
      hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
        h = int'(curH[i]);
        p = int'(curV[i]);
        if (!hit && (x + 50 > h) && (x < h + 75) && (feet <= p) && (feet + v >= p)) begin
          hit = 1'b1;
          mY = p - 50;
          mBounce = 1'b1;
          mT = 0;
        end
      end
      if (!hit) begin
        if (feet + v > 511) begin
          mY = 461; mDead = 1'b1; mGo = 1'b1;
        end else begin
          mY = mY + v;
          mT++;
        end
      end
    end
    mFalling = !mDead && (mT >= 54);
  endtask

  // Drives the current stimulus between edges, advances one tick and
  // compares every output with the model just after the edge.
  task automatic applyStimulus();
    @(negedge doodle_clk);
    rst         = curRst;
    bus.d_x     = curDx;
    bus.p1_hpos = curH[0];
    bus.p2_hpos = curH[1];
    bus.p3_hpos = curH[2];
    bus.p1_vpos = curV[0];
    bus.p2_vpos = curV[1];
    bus.p3_vpos = curV[2];
    @(posedge doodle_clk);
    modelStep();
    #1;
    checkOutput("model_d_y",       {1'b0, bus.d_y},        11'(mY));
    checkOutput("model_falling",   {10'b0, bus.falling},   {10'b0, mFalling});
    checkOutput("model_bounce",    {10'b0, bus.bounce},    {10'b0, mBounce});
    checkOutput("model_game_over", {10'b0, bus.game_over}, {10'b0, mGo});
  endtask

  task automatic platformsOff();
    for (int i = 0; i < 3; i++) begin
      curH[i] = OFF;
      curV[i] = 10'd0;
    end
  endtask

  initial begin
    bit seen;
    bit sawBounce;

    curRst = 1'b1;
    curDx  = 10'd400;
    platformsOff();
    mY = 461; mT = 0; mDead = 1'b0; mGo = 1'b0; mFalling = 1'b0; mBounce = 1'b0;

    // Scripted story: reset, full rise, apex hover, gravity ramp, landing.
    tbl[0]  = '{1'b1, 10'd400, OFF,     10'd0,   OFF, 10'd0,  2, 10'd461, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  1, 10'd458, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0, 49, 10'd311, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  3, 10'd311, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  1, 10'd311, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  4, 10'd315, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  1, 10'd317, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 10'd400, OFF,     10'd0,   OFF, 10'd0,  1, 10'd319, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 10'd400, 10'd380, 10'd400, OFF, 10'd0,  9, 10'd347, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 10'd400, 10'd380, 10'd400, OFF, 10'd0,  1, 10'd350, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 10'd400, 10'd380, 10'd400, OFF, 10'd0,  1, 10'd347, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 11; k++) begin
      curRst  = tbl[k].rst;
      curDx   = tbl[k].dx;
      curH[0] = tbl[k].p1h;
      curV[0] = tbl[k].p1v;
      curH[1] = tbl[k].p2h;
      curV[1] = tbl[k].p2v;
      curH[2] = OFF;
      curV[2] = 10'd0;
      for (int n = 0; n < tbl[k].ticks; n++) applyStimulus();
      checkOutput($sformatf("row%0d_d_y", k),       {1'b0, bus.d_y},        {1'b0, tbl[k].expDy});
      checkOutput($sformatf("row%0d_falling", k),   {10'b0, bus.falling},   {10'b0, tbl[k].expFalling});
      checkOutput($sformatf("row%0d_bounce", k),    {10'b0, bus.bounce},    {10'b0, tbl[k].expBounce});
      checkOutput($sformatf("row%0d_game_over", k), {10'b0, bus.game_over}, {10'b0, tbl[k].expGo});
    end

    // Priority: p1 and p2 are both crossed in the same tick; p1 must win.
    curH[0] = 10'd380; curV[0] = 10'd360;
    curH[1] = 10'd380; curV[1] = 10'd362;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      applyStimulus();
      if (bus.bounce === 1'b1) seen = 1'b1;
    end
    checkOutput("prio_bounce_seen", {10'b0, seen}, 11'd1);
    checkOutput("prio_d_y", {1'b0, bus.d_y}, 11'd310);

    // Edge contact on both sides: the doodle falls through and dies.
    curRst = 1'b1;
    platformsOff();
    applyStimulus();
    curRst  = 1'b0;
    curH[0] = 10'd450; curV[0] = 10'd400;
    curH[1] = 10'd325; curV[1] = 10'd400;
    seen = 1'b0;
    sawBounce = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      applyStimulus();
      if (bus.bounce === 1'b1) sawBounce = 1'b1;
      if (bus.game_over === 1'b1) seen = 1'b1;
    end
    checkOutput("edge_no_bounce", {10'b0, sawBounce}, 11'd0);
    checkOutput("death_seen", {10'b0, seen}, 11'd1);
    checkOutput("death_d_y", {1'b0, bus.d_y}, 11'd461);

    // Frozen in DEAD for 20 ticks.
    for (int n = 0; n < 20; n++) applyStimulus();
    checkOutput("dead_hold_d_y", {1'b0, bus.d_y}, 11'd461);
    checkOutput("dead_hold_go", {10'b0, bus.game_over}, 11'd1);
    checkOutput("dead_hold_falling", {10'b0, bus.falling}, 11'd0);

    // Reset out of DEAD, then the rise resumes.
    curRst = 1'b1;
    applyStimulus();
    checkOutput("dead_rst_go", {10'b0, bus.game_over}, 11'd0);
    checkOutput("dead_rst_d_y", {1'b0, bus.d_y}, 11'd461);
    curRst = 1'b0;
    applyStimulus();
    checkOutput("dead_rst_rise", {1'b0, bus.d_y}, 11'd458);

    // Randomized play: moving platforms, wandering d_x, occasional resets
    // (including mid-fall), all checked tick by tick against the model.
    for (int n = 0; n < 4000; n++) begin
      curRst = ($urandom_range(0, 299) == 0) || (mDead && $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) curDx = 10'($urandom_range(300, 500));
      if ($urandom_range(0, 7) == 0) begin
        int idx;
        idx = int'($urandom_range(0, 2));
        curH[idx] = 10'($urandom_range(300, 500));
        curV[idx] = 10'($urandom_range(150, 511));
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/doodle_y.md
# doodle_y

Vertical-motion controller for the doodle sprite; the vertical counterpart of the horizontal position block. Each `doodle_clk` tick it advances a rise/apex/fall jump cycle with gravity. It uses the horizontal position `d_x` and three platform positions to detect landings and re-trigger jumps. It flags game over when the doodle falls past the bottom of the play field, and feeds `d_y` to the renderer alongside `d_x`.

## Interface
- `hbp`, 295, left play-field edge (for reference only; no clamping here)
- `vtop`, 31, top play-field limit for `d_y`
- `bottom`, 511, bottom play-field edge
- `size`, 50, doodle sprite width and height (px)
- `p_width`, 75, platform width (px)
- `jump_ticks`, 50, rise duration in ticks
- `rise_step`, 3, px moved up per rise tick
- `apex_ticks`, 4, hover duration at apex
- `grav_div`, 4, fall ticks per +1 speed increment
- `v_max`, 6, maximum fall speed (px/tick)
- `doodle_clk`  in  1  game tick clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `d_x`  in  10  doodle left edge
- `p1_hpos`, `p2_hpos`, `p3_hpos`  in  10 each  platform left edges
- `p1_vpos`, `p2_vpos`, `p3_vpos`  in  10 each  platform top edges
- `d_y`  out  10  doodle top edge (registered)
- `falling`  out  1  high while in FALL
- `bounce`  out  1  one-tick pulse on landing
- `game_over`  out  1  sticky until `rst`

## Operation
- Feet coordinate is `feet = d_y + size`. All comparisons are 11-bit unsigned, with no wrap.
- States:
  - **RISE** is the reset state.
  - **APEX** hovers at the top of the jump.
  - **FALL** applies gravity and checks for landings.
  - **DEAD** is terminal until reset.
- Reset values:
  - `d_y = bottom - size` (461)
  - state RISE, rise counter 0, apex counter 0
  - fall speed `v = 1`, gravity counter 0
  - `falling = 0`, `bounce = 0`, `game_over = 0`
- RISE:
  - Each tick, `d_y <= max(d_y - rise_step, vtop)`. The clamp never underflows.
  - The counter increments each tick. After `jump_ticks` ticks, go to APEX.
  - There is no landing check while rising.
- APEX:
  - `d_y` holds for `apex_ticks` ticks.
  - On exit, go to FALL with `v = 1` and gravity counter 0.
- FALL, evaluated each tick:
  - **Landing test per platform i:**
    - overlap: `d_x + size > pi_hpos` and `d_x < pi_hpos + p_width` (edge contact is not overlap)
    - crossing: `feet <= pi_vpos` and `feet + v >= pi_vpos`
  - **If any platform lands:**
    - Priority is p1 > p2 > p3.
    - `d_y <= pi_vpos - size`, `bounce <= 1`.
    - Go to RISE with its counter cleared.
  - **Else, if `feet + v > bottom`:**
    - `d_y <= bottom - size`, `game_over <= 1`.
    - Go to DEAD.
  - **Else:**
    - `d_y <= d_y + v`.
    - The gravity counter increments. When it reaches `grav_div - 1`, it clears and `v <= min(v + 1, v_max)`.
- DEAD:
  - All registers hold, `game_over = 1`.
  - Only `rst` exits DEAD.
- `falling` is registered and equals (next state == FALL).
- `bounce` is high for exactly the one tick after a landing edge, and 0 otherwise.

## Timing
- All outputs are registered. They update on the same `doodle_clk` edge that evaluates the state.
- Platform and `d_x` inputs are sampled at the edge. Landing uses the pre-edge `d_y` and `v`.
- A landing snaps `d_y` in the same edge. The first rise step happens on the following edge.
- A full jump from reset with no platforms:
  - 50 RISE ticks
  - 4 APEX ticks
  - FALL until DEAD
- `rst` wins over every state, including mid-FALL and DEAD. The reset values appear on the edge where `rst` is sampled high.
- The platform inputs may change any tick; the block makes no assumption of stability.

## Test plan
1. **Reset and rise:** hold `rst` for 2 ticks, release → `d_y = 461`, then 458 after 1 tick, 311 after 50 ticks, 311 held for 4 ticks, then `falling = 1`.
2. **Gravity ramp:** no overlapping platforms, starting at 311 → `d_y` goes 312, 313, 314, 315, 317, 319, …; speed saturates at 6 and never exceeds it.
3. **Landing:** `d_x = 400`, `p1_hpos = 380`, `p1_vpos = 400`, falling from 311 → `d_y` snaps to 350; `bounce` is high for 1 tick; `falling = 0`; next tick `d_y = 347`.
4. **Edge contact:** `p1_hpos = d_x + 50`, `p1_vpos = 400` → no landing; the doodle passes through; `bounce` stays 0.
5. **Priority:** p1 and p2 both satisfy crossing and overlap with `p1_vpos = 360`, `p2_vpos = 362` → `d_y = 310`, which is the p1 result.
6. **Death and reset:** no platforms → `game_over = 1`, `d_y = 461`, frozen for 20 ticks. Assert `rst` mid-DEAD → `game_over = 0`, state RISE, and the rise resumes.
